uart_status_tx: RTL and testbench
=================================

// Module: uart_status_tx
// PURPOSE
//  Return-path framer for the UART control link. On request, it snapshots the current port routing map, a command id
//  and status flags, then serialises them as a fixed byte frame through the byte-level uart_tx
//  (tx_data / tx_pluse / tx_busy handshake). It sits between the command decoder and uart_tx, and reports
//  the applied configuration back to the host.
// PARAMETERS
//  SYNC_BYTE  8'hA5  first byte of every frame
//  GUARD_CYC  2      cycles after tx_pluse during which tx_busy is ignored (covers uart_tx busy-rise latency); min 1
//  GAP_CYC    0      extra idle cycles inserted after tx_busy falls, before the next byte pulse
// PORTS
//  clk          in   1  system clock
//  sys_rst      in   1  synchronous reset, active-high
//  send_req     in   1  one-cycle request to send a status frame
//  cmd_id       in   8  command id echoed in the frame
//  eth_port     in   4  routing map fields, sampled at snapshot
//  camera_port  in   4
//  pcie_port    in   4
//  hdmi_port    in   4
//  flags        in   8  status flags, sampled at snapshot
//  tx_busy      in   1  from uart_tx: byte in flight
//  tx_data      out  8  byte to uart_tx; stable from its pulse until the next pulse
//  tx_pluse     out  1  one-cycle strobe to uart_tx
//  frame_busy   out  1  high from request acceptance until frame_done
//  frame_done   out  1  one-cycle pulse when the last byte has completed
//  req_pend     out  1  a request arrived while busy and is queued (one-deep)
// BEHAVIOUR
//  Reset: all outputs are 0, the FSM is in IDLE, the snapshot is cleared and pending is cleared. Reset applies on the
//   next edge even in mid-frame: tx_pluse is never asserted in the cycle after sys_rst is sampled high.
//  Frame: B0=SYNC_BYTE, B1=cmd_id, B2={eth_port,camera_port}, B3={pcie_port,hdmi_port}, B4=flags,
//   B5=checksum (only if the macro is defined). All fields come from the snapshot, never from live inputs.
//  FSM states: IDLE -> PULSE -> GUARD -> WAIT -> GAP -> (PULSE | DONE) -> IDLE.
//   IDLE: when send_req=1, capture the snapshot on that edge, set frame_busy=1 and go to PULSE.
//   PULSE: tx_pluse=1 for exactly 1 cycle, tx_data=B[idx]; first pulse is 1 clk after send_req.
//   GUARD: GUARD_CYC cycles; tx_busy is ignored.
//   WAIT: stay until tx_busy=0. If tx_busy never rose, exit immediately after GUARD.
//   GAP: GAP_CYC cycles (skipped when 0). Then idx+1 -> PULSE, or go to DONE after the last byte.
//   DONE: frame_done=1 and frame_busy=0 for 1 cycle. If req_pend=1, clear it, take a fresh snapshot in this cycle,
//    and enter PULSE on the next edge. Otherwise go to IDLE.
//  send_req while frame_busy=1: sets req_pend. Further requests while pending merge; no counter is kept.
//   A send_req in the DONE cycle is treated as pending.
//  Byte index wraps to 0 only via DONE, never mid-frame. The snapshot is held until the next capture.
//  No combinational path from inputs to outputs; tx_data and tx_pluse are registered.
// CONFIGURATION
//  UART_STATUS_TX_CKSUM_EN defined: 6-byte frame. B5 = XOR of B0..B4.
//  Not defined: 5-byte frame; frame_done follows B4. No checksum logic is synthesised.
// TESTING
//  1) Reset, then idle 20 clk -> tx_pluse, frame_busy, frame_done and req_pend all stay 0, and tx_data=0.
//  2) cmd_id=02, map eth1/cam2/pcie3/hdmi0, flags=01, send_req; uart_tx model busy 3 clk after each pulse
//     -> bytes A5 02 12 30 01 [84 with CKSUM_EN]; first pulse 1 clk after send_req; one frame_done.
//  3) Change the map inputs mid-frame -> transmitted bytes still match the values at the accepting edge.
//  4) Three send_req pulses during one frame -> req_pend=1. After the first frame_done, exactly one more frame
//     follows using the snapshot from the DONE cycle, then IDLE.
//  5) Model never raises tx_busy -> pulses are spaced 1+GUARD_CYC+GAP_CYC clk apart (3 clk at defaults);
//     the frame still completes.
//  6) sys_rst asserted during B2 WAIT -> the next cycle has all outputs 0 and IDLE. A new send_req then restarts
//     the frame from A5.

Source files
------------

// File: rtl/uart_status_tx_if.sv
// uart_status_tx_if: byte-level handshake between the status framer and uart_tx.
// The master drives tx_data/tx_pluse; uart_tx answers with tx_busy.
interface uart_status_tx_if;
  logic [7:0] tx_data;
  logic       tx_pluse;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_pluse,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_pluse,
    output tx_busy
  );
endinterface

// File: rtl/uart_status_tx.sv
// uart_status_tx: snapshots routing map, cmd id and flags, then frames them to uart_tx.
// Define UART_STATUS_TX_CKSUM_EN to append an XOR checksum byte (6-byte frame).
module uart_status_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         GUARD_CYC = 2,
  parameter int         GAP_CYC   = 0
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    send_req,
  input  logic [7:0]              cmd_id,
  input  logic [3:0]              eth_port,
  input  logic [3:0]              camera_port,
  input  logic [3:0]              pcie_port,
  input  logic [3:0]              hdmi_port,
  input  logic [7:0]              flags,
  uart_status_tx_if.master        tx,
  output logic                    frame_busy,
  output logic                    frame_done,
  output logic                    req_pend
);

`ifdef UART_STATUS_TX_CKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam int CW = 8;
  localparam int IW = 3;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    GUARD,
    WAIT,
    GAP,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic          pend_n;
  logic          capture;
  logic          adv;
  logic          step;
  logic          last;
  logic [7:0]    byte_n;

  logic [7:0]    s_cmd;
  logic [15:0]   s_map;
  logic [7:0]    s_flags;

  assign last = (idx == IW'(NBYTES - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    capture = 1'b0;
    adv     = 1'b0;
    step    = 1'b0;
    pend_n  = req_pend | (send_req & (state != IDLE));
    unique case (state)
      IDLE: begin
        if (send_req | req_pend) begin
          capture = 1'b1;
          pend_n  = 1'b0;
          idx_n   = '0;
          state_n = PULSE;
        end
      end
      PULSE: begin
        state_n = GUARD;
        cnt_n   = CW'(GUARD_CYC - 1);
      end
      GUARD: begin
        if (cnt != '0)
          cnt_n = cnt - CW'(1);
        else if (tx.tx_busy)
          state_n = WAIT;
        else
          adv = 1'b1;
      end
      WAIT: begin
        if (!tx.tx_busy)
          adv = 1'b1;
      end
      GAP: begin
        if (cnt != '0)
          cnt_n = cnt - CW'(1);
        else
          step = 1'b1;
      end
      DONE: begin
        // a request landing in DONE is kept for the following frame
        pend_n = send_req;
        if (req_pend) begin
          capture = 1'b1;
          idx_n   = '0;
          state_n = PULSE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (adv && (GAP_CYC > 0)) begin
      state_n = GAP;
      cnt_n   = CW'(GAP_CYC - 1);
    end
    if ((adv && (GAP_CYC == 0)) || step) begin
      if (last) begin
        state_n = DONE;
      end else begin
        state_n = PULSE;
        idx_n   = idx + IW'(1);
      end
    end
  end

  // byte 0 is constant, so a same-edge capture never feeds a stale field
  always_comb begin
    byte_n = 8'h00;
    unique case (idx_n)
      3'd0: byte_n = SYNC_BYTE;
      3'd1: byte_n = s_cmd;
      3'd2: byte_n = s_map[15:8];
      3'd3: byte_n = s_map[7:0];
      3'd4: byte_n = s_flags;
`ifdef UART_STATUS_TX_CKSUM_EN
      3'd5: byte_n = SYNC_BYTE ^ s_cmd ^ s_map[15:8]
                   ^ s_map[7:0] ^ s_flags;
`endif
      default: byte_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      req_pend    <= 1'b0;
      s_cmd       <= '0;
      s_map       <= '0;
      s_flags     <= '0;
      tx.tx_data  <= '0;
      tx.tx_pluse <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      req_pend <= pend_n;
      if (capture) begin
        s_cmd   <= cmd_id;
        s_map   <= {eth_port, camera_port,
                    pcie_port, hdmi_port};
        s_flags <= flags;
      end
      tx.tx_pluse <= (state_n == PULSE);
      if (state_n == PULSE)
        tx.tx_data <= byte_n;
      frame_busy <= (state_n == PULSE) || (state_n == GUARD)
                 || (state_n == WAIT)  || (state_n == GAP);
      frame_done <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// tb_uart_status_tx: directed bench for the status framer with a uart_tx busy model.
// Honours UART_STATUS_TX_CKSUM_EN for frame length and checksum byte.
module tb_uart_status_tx;

`ifdef UART_STATUS_TX_CKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       send_req = 1'b0;
  logic [7:0] cmd_id = '0;
  logic [3:0] eth_port = '0;
  logic [3:0] camera_port = '0;
  logic [3:0] pcie_port = '0;
  logic [3:0] hdmi_port = '0;
  logic [7:0] flags = '0;
  logic       frame_busy;
  logic       frame_done;
  logic       req_pend;

  uart_status_tx_if txi ();

  uart_status_tx dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .send_req    (send_req),
    .cmd_id      (cmd_id),
    .eth_port    (eth_port),
    .camera_port (camera_port),
    .pcie_port   (pcie_port),
    .hdmi_port   (hdmi_port),
    .flags       (flags),
    .tx          (txi),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .req_pend    (req_pend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for 3 clk after each pulse
  bit model_en = 1'b1;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (model_en && txi.tx_pluse)
      busy_cnt <= 3;
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
  end
  assign txi.tx_busy = (busy_cnt != 0);

  logic [7:0] pdata[$];
  int         pcyc[$];
  int         dcyc[$];
  always @(posedge clk) begin
    #1;
    if (txi.tx_pluse) begin
      pdata.push_back(txi.tx_data);
      pcyc.push_back(cyc);
    end
    if (frame_done)
      dcyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic clear_log();
    pdata.delete();
    pcyc.delete();
    dcyc.delete();
  endtask

  task automatic set_in(input logic [7:0] c, input logic [3:0] e,
                        input logic [3:0] ca, input logic [3:0] p,
                        input logic [3:0] h, input logic [7:0] f);
    cmd_id = c;
    eth_port = e;
    camera_port = ca;
    pcie_port = p;
    hdmi_port = h;
    flags = f;
  endtask

  task automatic pulse_req(output int rc);
    @(negedge clk);
    send_req = 1'b1;
    rc = cyc;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dcyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit sp, sb, sd, sr, sdat;
    sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    sp = 0; sb = 0; sd = 0; sr = 0; sdat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sp   |= (txi.tx_pluse !== 1'b0);
      sb   |= (frame_busy !== 1'b0);
      sd   |= (frame_done !== 1'b0);
      sr   |= (req_pend !== 1'b0);
      sdat |= (txi.tx_data !== 8'h00);
    end
    n_cmp++;
    if (sp !== 1'b0) begin
      n_err++; $display("FAIL reset_pluse: got %b want 0", sp);
    end
    n_cmp++;
    if (sb !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", sb);
    end
    n_cmp++;
    if (sd !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b want 0", sd);
    end
    n_cmp++;
    if (sr !== 1'b0) begin
      n_err++; $display("FAIL reset_pend: got %b want 0", sr);
    end
    n_cmp++;
    if (sdat !== 1'b0) begin
      n_err++; $display("FAIL reset_data: got %b want 0", sdat);
    end
  endtask

  task automatic test_frame();
    logic [47:0] exp;
    int rc;
    bit ok;
    exp = 48'h84_01_30_12_02_A5;
    clear_log();
    set_in(8'h02, 4'd1, 4'd2, 4'd3, 4'd0, 8'h01);
    pulse_req(rc);
    wait_done(1, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL frame_timeout: got %b want 1", ok);
    end
    n_cmp++;
    if (pdata.size() != NB) begin
      n_err++;
      $display("FAIL frame_len: got %0d want %0d", pdata.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (pdata[i] !== exp[i*8 +: 8]) begin
          n_err++;
          $display("FAIL frame_b%0d: got %h want %h",
                   i, pdata[i], exp[i*8 +: 8]);
        end
      end
      n_cmp++;
      if (pcyc[0] != rc + 1) begin
        n_err++;
        $display("FAIL frame_lat: got %0d want %0d", pcyc[0], rc + 1);
      end
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (dcyc.size() != 1) begin
      n_err++; $display("FAIL frame_done_cnt: got %0d want 1", dcyc.size());
    end
    n_cmp++;
    if (frame_busy !== 1'b0) begin
      n_err++; $display("FAIL frame_busy_end: got %b want 0", frame_busy);
    end
  endtask

  task automatic test_snapshot();
    logic [47:0] exp;
    int rc;
    bit ok;
    exp = 48'h69_F0_CD_AB_5A_A5;
    clear_log();
    set_in(8'h5A, 4'hA, 4'hB, 4'hC, 4'hD, 8'hF0);
    pulse_req(rc);
    repeat (4) @(negedge clk);
    set_in(8'hFF, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
    wait_done(1, ok);
    n_cmp++;
    if (ok !== 1'b1 || pdata.size() != NB) begin
      n_err++;
      $display("FAIL snap_len: got %0d want %0d", pdata.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (pdata[i] !== exp[i*8 +: 8]) begin
          n_err++;
          $display("FAIL snap_b%0d: got %h want %h",
                   i, pdata[i], exp[i*8 +: 8]);
        end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp;
    int rc;
    bit ok;
    exp = {48'hE9_40_78_56_22_A5, 48'h12_80_34_12_11_A5};
    clear_log();
    set_in(8'h11, 4'd1, 4'd2, 4'd3, 4'd4, 8'h80);
    pulse_req(rc);
    set_in(8'h22, 4'd5, 4'd6, 4'd7, 4'd8, 8'h40);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
    end
    n_cmp++;
    if (req_pend !== 1'b1) begin
      n_err++; $display("FAIL b2b_pend: got %b want 1", req_pend);
    end
    wait_done(2, ok);
    n_cmp++;
    if (ok !== 1'b1 || pdata.size() != 2 * NB) begin
      n_err++;
      $display("FAIL b2b_len: got %0d want %0d", pdata.size(), 2 * NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (pdata[i] !== exp[i*8 +: 8]) begin
          n_err++;
          $display("FAIL b2b_f0_b%0d: got %h want %h",
                   i, pdata[i], exp[i*8 +: 8]);
        end
        n_cmp++;
        if (pdata[NB+i] !== exp[48+i*8 +: 8]) begin
          n_err++;
          $display("FAIL b2b_f1_b%0d: got %h want %h",
                   i, pdata[NB+i], exp[48+i*8 +: 8]);
        end
      end
      n_cmp++;
      if (pcyc[NB] != dcyc[0] + 1) begin
        n_err++;
        $display("FAIL b2b_restart: got %0d want %0d",
                 pcyc[NB], dcyc[0] + 1);
      end
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (pdata.size() != 2 * NB || dcyc.size() != 2) begin
      n_err++;
      $display("FAIL b2b_extra: got %0d/%0d want %0d/2",
               pdata.size(), dcyc.size(), 2 * NB);
    end
    n_cmp++;
    if ({req_pend, frame_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_idle: got %b%b want 00", req_pend, frame_busy);
    end
  endtask

  task automatic test_no_busy();
    int rc;
    bit ok;
    model_en = 1'b0;
    clear_log();
    set_in(8'h02, 4'd1, 4'd2, 4'd3, 4'd0, 8'h01);
    pulse_req(rc);
    wait_done(1, ok);
    n_cmp++;
    if (ok !== 1'b1 || pdata.size() != NB) begin
      n_err++;
      $display("FAIL nobusy_len: got %0d want %0d", pdata.size(), NB);
    end else begin
      for (int i = 1; i < NB; i++) begin
        n_cmp++;
        if (pcyc[i] - pcyc[i-1] != 3) begin
          n_err++;
          $display("FAIL nobusy_gap%0d: got %0d want 3",
                   i, pcyc[i] - pcyc[i-1]);
        end
      end
      n_cmp++;
      if (dcyc[0] != pcyc[NB-1] + 3) begin
        n_err++;
        $display("FAIL nobusy_done: got %0d want %0d",
                 dcyc[0], pcyc[NB-1] + 3);
      end
    end
    repeat (5) @(negedge clk);
    model_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [47:0] exp;
    int rc;
    bit ok;
    exp = 48'h84_01_30_12_02_A5;
    clear_log();
    set_in(8'h02, 4'd1, 4'd2, 4'd3, 4'd0, 8'h01);
    pulse_req(rc);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pdata.size() >= 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL mid_b2_seen: got %0d want 3", pdata.size());
    end
    @(negedge clk);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_pend !== 1'b1) begin
      n_err++; $display("FAIL mid_pend: got %b want 1", req_pend);
    end
    sys_rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (txi.tx_pluse !== 1'b0 || txi.tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_rst_tx: got %b/%h want 0/00",
               txi.tx_pluse, txi.tx_data);
    end
    n_cmp++;
    if ({frame_busy, frame_done, req_pend} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_rst_flags: got %b%b%b want 000",
               frame_busy, frame_done, req_pend);
    end
    n_cmp++;
    if (pdata.size() != 3) begin
      n_err++; $display("FAIL mid_rst_pulses: got %0d want 3", pdata.size());
    end
    sys_rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_log();
    pulse_req(rc);
    wait_done(1, ok);
    n_cmp++;
    if (ok !== 1'b1 || pdata.size() != NB) begin
      n_err++;
      $display("FAIL mid_restart_len: got %0d want %0d", pdata.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (pdata[i] !== exp[i*8 +: 8]) begin
          n_err++;
          $display("FAIL mid_restart_b%0d: got %h want %h",
                   i, pdata[i], exp[i*8 +: 8]);
        end
      end
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_back_to_back();
    test_no_busy();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
